// File: rtl/uart_tx.sv
// UART transmitter: serialises one parallel word per frame as a start bit,
// the data LSB first, an optional even/odd parity bit and one stop bit.
// Each bit is held for max(prescale_tx,1) clocks. The line and busy flag are
// registered, so a request accepted at one edge shows the start bit from
// that same edge.
module uart_tx #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] p_data_tx,
    input  logic              data_valid_tx,
    input  logic              parity_en_tx,
    input  logic              parity_type_tx,
    input  logic [PWIDTH-1:0] prescale_tx,
    output logic              s_data_tx,
    output logic              busy_tx
);

    localparam int IWIDTH = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_next;
    logic [DWIDTH-1:0] data_reg, data_next;
    logic              par_en_reg, par_en_next;
    logic              par_type_reg, par_type_next;
    logic [PWIDTH-1:0] p_reg, p_next;
    logic [PWIDTH-1:0] timer, timer_next;
    logic [IWIDTH-1:0] idx, idx_next;
    logic              line_next;
    logic              busy_next;
    logic              bit_done;
    logic              par_bit;

    // The current bit has been on the line for its full P clocks
    assign bit_done = (timer == (p_reg - PWIDTH'(1)));

    // Next-state logic: accept a request only in IDLE, then step through the
    // frame one bit time at a time using the configuration frozen at accept
    always_comb begin
        state_next    = state;
        data_next     = data_reg;
        par_en_next   = par_en_reg;
        par_type_next = par_type_reg;
        p_next        = p_reg;
        timer_next    = timer;
        idx_next      = idx;
        case (state)
            IDLE: begin
                if (data_valid_tx) begin
                    state_next    = START;
                    data_next     = p_data_tx;
                    par_en_next   = parity_en_tx;
                    par_type_next = parity_type_tx;
                    p_next        = (prescale_tx == '0) ? PWIDTH'(1) : prescale_tx;
                    timer_next    = '0;
                    idx_next      = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_next = '0;
                    idx_next   = '0;
                    state_next = DATA;
                end else begin
                    timer_next = timer + PWIDTH'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_next = '0;
                    if (idx == IWIDTH'(DWIDTH - 1)) begin
                        state_next = par_en_reg ? PARITY : STOP;
                    end else begin
                        idx_next = idx + IWIDTH'(1);
                    end
                end else begin
                    timer_next = timer + PWIDTH'(1);
                end
            end
            PARITY: begin
                if (bit_done) begin
                    timer_next = '0;
                    state_next = STOP;
                end else begin
                    timer_next = timer + PWIDTH'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer + PWIDTH'(1);
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
                idx_next   = '0;
            end
        endcase
    end

    // Parity of the word being sent; odd parity is the inverse of even
    assign par_bit = par_type_next ? ~(^data_next) : (^data_next);

    // Output decode from the next state so the line and busy are registered
    // alongside the state and change on the same edge as it
    always_comb begin
        line_next = 1'b1;
        busy_next = 1'b1;
        case (state_next)
            IDLE:    busy_next = 1'b0;
            START:   line_next = 1'b0;
            DATA:    line_next = data_next[idx_next];
            PARITY:  line_next = par_bit;
            STOP:    line_next = 1'b1;
            default: busy_next = 1'b0;
        endcase
    end

    // State, frozen configuration, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            data_reg     <= '0;
            par_en_reg   <= 1'b0;
            par_type_reg <= 1'b0;
            p_reg        <= '0;
            timer        <= '0;
            idx          <= '0;
            s_data_tx    <= 1'b1;
            busy_tx      <= 1'b0;
        end else begin
            state        <= state_next;
            data_reg     <= data_next;
            par_en_reg   <= par_en_next;
            par_type_reg <= par_type_next;
            p_reg        <= p_next;
            timer        <= timer_next;
            idx          <= idx_next;
            s_data_tx    <= line_next;
            busy_tx      <= busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: stimulus pushes each expected frame onto a queue,
// and an independent monitor pops it when busy_tx rises and checks the line
// clock by clock against a frame model, then checks the return to idle.
module tb_uart_tx;

    localparam int DWIDTH = 8;
    localparam int PWIDTH = 6;

    logic              clk;
    logic              rst;
    logic [DWIDTH-1:0] p_data_tx;
    logic              data_valid_tx;
    logic              parity_en_tx;
    logic              parity_type_tx;
    logic [PWIDTH-1:0] prescale_tx;
    logic              s_data_tx;
    logic              busy_tx;

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         ptype;
        int         p;
        int         len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_busy = 0;

    uart_tx #(.DWIDTH(DWIDTH), .PWIDTH(PWIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .p_data_tx      (p_data_tx),
        .data_valid_tx  (data_valid_tx),
        .parity_en_tx   (parity_en_tx),
        .parity_type_tx (parity_type_tx),
        .prescale_tx    (prescale_tx),
        .s_data_tx      (s_data_tx),
        .busy_tx        (busy_tx)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run can never hang
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, actual, expected);
        end
    endtask

    function automatic int frameLen(input bit pen, input int p);
        return p * (pen ? 11 : 10);
    endfunction

    // Expected line level c clocks into a frame
    function automatic bit expBit(input exp_t e, input int c);
        int b;
        int ones;
        b = c / e.p;
        if (b == 0) return 1'b0;
        if (b <= 8) return e.data[b-1];
        if (e.pen && b == 9) begin
            ones = 0;
            for (int i = 0; i < 8; i++) ones += int'(e.data[i]);
            return ((ones % 2) == 1) ^ e.ptype;
        end
        return 1'b1;
    endfunction

    // Issue one request once the transmitter is idle and queue its frame;
    // cut_len>0 marks a frame that will be aborted after that many clocks
    task automatic applyStimulus(input logic [7:0] data, input bit pen, input bit ptype,
                                 input int prescale, input int cut_len);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        while (busy_tx !== 1'b0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) checkOutput("idle_timeout", 1, 0);
        p_data_tx      = data;
        parity_en_tx   = pen;
        parity_type_tx = ptype;
        prescale_tx    = PWIDTH'(prescale);
        data_valid_tx  = 1'b1;
        e.data  = data;
        e.pen   = pen;
        e.ptype = ptype;
        e.p     = (prescale == 0) ? 1 : prescale;
        e.len   = (cut_len > 0) ? cut_len : frameLen(pen, e.p);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        data_valid_tx = 1'b0;
    endtask

    // Wait until every queued frame has been checked by the monitor
    task automatic waitDone();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || mon_busy) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) checkOutput("frame_timeout", 1, 0);
        @(negedge clk);
    endtask

    // Monitor: on each rising busy_tx pop the next expected frame and check it
    initial begin
        exp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_tx === 1'b1 && !prev) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame", 1, 0);
                    prev = 1'b1;
                end else begin
                    mon_busy = 1'b1;
                    e = exp_q.pop_front();
                    for (int c = 0; c < e.len; c++) begin
                        if (c > 0) @(negedge clk);
                        checkOutput("frame_line", int'(s_data_tx), int'(expBit(e, c)));
                        checkOutput("frame_busy", int'(busy_tx), 1);
                    end
                    @(negedge clk);
                    checkOutput("end_busy", int'(busy_tx), 0);
                    checkOutput("end_line", int'(s_data_tx), 1);
                    prev = busy_tx;
                    mon_busy = 1'b0;
                end
            end else begin
                prev = (busy_tx === 1'b1);
            end
        end
    end

    initial begin
        logic [7:0] word;
        rst            = 1'b1;
        data_valid_tx  = 1'b1;
        p_data_tx      = 8'h00;
        parity_en_tx   = 1'b0;
        parity_type_tx = 1'b0;
        prescale_tx    = 6'd1;

        // Reset held three clocks with inputs toggling, then released
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_line", int'(s_data_tx), 1);
            checkOutput("reset_busy", int'(busy_tx), 0);
            p_data_tx     = ~p_data_tx;
            parity_en_tx  = ~parity_en_tx;
            data_valid_tx = ~data_valid_tx;
        end
        rst           = 1'b0;
        data_valid_tx = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_line", int'(s_data_tx), 1);
        checkOutput("post_reset_busy", int'(busy_tx), 0);

        $display("[TB] P=4 0xA5 even parity");
        applyStimulus(8'hA5, 1'b1, 1'b0, 4, 0);
        waitDone();

        $display("[TB] P=4 0xA5 odd parity");
        applyStimulus(8'hA5, 1'b1, 1'b1, 4, 0);
        waitDone();

        $display("[TB] P=1 0x3C no parity");
        applyStimulus(8'h3C, 1'b0, 1'b0, 1, 0);
        waitDone();

        $display("[TB] prescale 0 0xFF no parity");
        applyStimulus(8'hFF, 1'b0, 1'b0, 0, 0);
        waitDone();

        $display("[TB] mid-frame request and prescale change ignored");
        applyStimulus(8'hA5, 1'b1, 1'b0, 3, 0);
        repeat (7) @(negedge clk);
        p_data_tx     = 8'h55;
        prescale_tx   = 6'd1;
        parity_en_tx  = 1'b0;
        data_valid_tx = 1'b1;
        @(posedge clk);
        #1;
        data_valid_tx = 1'b0;
        waitDone();
        repeat (3) @(negedge clk);
        checkOutput("no_queued_frame", int'(busy_tx), 0);

        $display("[TB] reset during data bit 3");
        applyStimulus(8'hC3, 1'b0, 1'b0, 2, 10);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_line", int'(s_data_tx), 1);
        checkOutput("abort_busy", int'(busy_tx), 0);
        rst = 1'b0;
        waitDone();
        applyStimulus(8'h96, 1'b1, 1'b1, 1, 0);
        waitDone();

        $display("[TB] 16 back-to-back words");
        for (int i = 0; i < 16; i++) begin
            word = 8'($urandom);
            applyStimulus(word, 1'(i % 2), 1'(i % 3 == 0), 2, 0);
        end
        waitDone();

        checkOutput("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
